conv_ctrl: RTL and testbench

CONV_CTRL -- requirements
Module: conv_ctrl

---
 rtl/conv_ctrl.sv | 147 ++++++++++++++
 tb/tb_conv_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl.sv
// Sequencer for a sliding-window convolutor: streams an N x N image out of memory
// row-major and tags each convolutor result with its window's top-left coordinate.
module conv_ctrl #(
    parameter int N          = 4,
    parameter int K_SIZE     = 3,
    parameter int CONV_LAT   = 1,
    parameter int ADDR_WIDTH = 14,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  hold_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  conv_en_o,
    output logic                  out_valid_o,
    output logic [IDX_WIDTH-1:0]  out_row_o,
    output logic [IDX_WIDTH-1:0]  out_col_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int DW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
    localparam logic [DW-1:0]         DLAST     = DW'(CONV_LAT - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N * N - 1);
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX  = IDX_WIDTH'(N - 1);
    localparam logic [IDX_WIDTH-1:0]  KM1       = IDX_WIDTH'(K_SIZE - 1);

    if (N >= 2 ** IDX_WIDTH) begin : g_bad_idx_width
        $error("conv_ctrl: N does not fit in IDX_WIDTH");
    end
    if (N * N > 2 ** ADDR_WIDTH) begin : g_bad_addr_width
        $error("conv_ctrl: N*N does not fit in ADDR_WIDTH");
    end
    if (K_SIZE > N || K_SIZE < 1 || CONV_LAT < 1) begin : g_bad_geometry
        $error("conv_ctrl: need 1 <= K_SIZE <= N and CONV_LAT >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [IDX_WIDTH-1:0]  r_rd_row;
    logic [IDX_WIDTH-1:0]  r_rd_col;
    logic [IDX_WIDTH-1:0]  r_push_row;
    logic [IDX_WIDTH-1:0]  r_push_col;
    logic                  r_conv_en;
    logic                  r_done;
    logic [DW-1:0]         r_drain_cnt;
    logic                  r_tvld [CONV_LAT];
    logic [IDX_WIDTH-1:0]  r_trow [CONV_LAT];
    logic [IDX_WIDTH-1:0]  r_tcol [CONV_LAT];

    logic                  w_mem_en;
    logic                  w_adv;
    logic                  w_last_rd;
    logic                  w_drain_end;
    logic                  w_tag_vld;

    assign w_mem_en    = (r_state == S_RUN) && !hold_i;
    // The in-flight push always lands, even under hold, so the chain stays aligned
    // with the convolutor's own shift register.
    assign w_adv       = r_conv_en || ((r_state == S_DRAIN) && !hold_i);
    assign w_last_rd   = (r_addr == LAST_ADDR);
    assign w_drain_end = (r_state == S_DRAIN) && w_adv && !r_conv_en && (r_drain_cnt == DLAST);
    assign w_tag_vld   = r_conv_en && (r_push_row >= KM1) && (r_push_col >= KM1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i && !hold_i) w_next = S_RUN;
            S_RUN:   if (w_mem_en && w_last_rd) w_next = S_DRAIN;
            S_DRAIN: if (w_drain_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_rd_row    <= '0;
            r_rd_col    <= '0;
            r_push_row  <= '0;
            r_push_col  <= '0;
            r_conv_en   <= 1'b0;
            r_done      <= 1'b0;
            r_drain_cnt <= '0;
        end else begin
            r_state   <= w_next;
            r_conv_en <= w_mem_en;
            r_done    <= w_drain_end;
            if (r_state == S_IDLE && w_next == S_RUN) begin
                r_addr      <= '0;
                r_rd_row    <= '0;
                r_rd_col    <= '0;
                r_drain_cnt <= '0;
            end else if (w_mem_en && !w_last_rd) begin
                r_addr <= r_addr + 1'b1;
                if (r_rd_col == LAST_IDX) begin
                    r_rd_col <= '0;
                    r_rd_row <= r_rd_row + 1'b1;
                end else begin
                    r_rd_col <= r_rd_col + 1'b1;
                end
            end
            if (w_mem_en) begin
                r_push_row <= r_rd_row;
                r_push_col <= r_rd_col;
            end
            if (r_state == S_DRAIN && w_adv && !r_conv_en)
                r_drain_cnt <= r_drain_cnt + DW'(1);
        end
    end

    // Tag chain: one stage per convolutor pipeline step, tail lines up with its result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CONV_LAT; i++) begin
                r_tvld[i] <= 1'b0;
                r_trow[i] <= '0;
                r_tcol[i] <= '0;
            end
        end else if (w_adv) begin
            r_tvld[0] <= w_tag_vld;
            r_trow[0] <= r_push_row - KM1;
            r_tcol[0] <= r_push_col - KM1;
            for (int i = 1; i < CONV_LAT; i++) begin
                r_tvld[i] <= r_tvld[i-1];
                r_trow[i] <= r_trow[i-1];
                r_tcol[i] <= r_tcol[i-1];
            end
        end
    end

    assign mem_en_o    = w_mem_en;
    assign mem_addr_o  = (r_state == S_RUN) ? r_addr : '0;
    assign conv_en_o   = r_conv_en;
    assign out_valid_o = r_tvld[CONV_LAT-1] && w_adv;
    assign out_row_o   = r_trow[CONV_LAT-1];
    assign out_col_o   = r_tcol[CONV_LAT-1];
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = r_done;

endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl: two instances (4/3/1 and 8/3/3) checked every cycle against a
// transaction-level model, plus literal event timings for the directed frames.
module tb_conv_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        st_a, hd_a, st_b, hd_b;
    logic        men_a, cen_a, ov_a, bsy_a, dn_a;
    logic        men_b, cen_b, ov_b, bsy_b, dn_b;
    logic [13:0] addr_a, addr_b;
    logic [7:0]  row_a, col_a, row_b, col_b;

    conv_ctrl #(.N(4), .K_SIZE(3), .CONV_LAT(1), .ADDR_WIDTH(14), .IDX_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .start_i(st_a), .hold_i(hd_a),
        .mem_en_o(men_a), .mem_addr_o(addr_a), .conv_en_o(cen_a),
        .out_valid_o(ov_a), .out_row_o(row_a), .out_col_o(col_a),
        .busy_o(bsy_a), .done_o(dn_a));

    conv_ctrl #(.N(8), .K_SIZE(3), .CONV_LAT(3), .ADDR_WIDTH(14), .IDX_WIDTH(8)) dut_b (
        .clk(clk), .rst(rst), .start_i(st_b), .hold_i(hd_b),
        .mem_en_o(men_b), .mem_addr_o(addr_b), .conv_en_o(cen_b),
        .out_valid_o(ov_b), .out_row_o(row_b), .out_col_o(col_b),
        .busy_o(bsy_b), .done_o(dn_b));

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit chk_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: per instance, a frame is a run of N*N reads; each read becomes a push one
    // cycle later; each pushed window tag emerges after CONV_LAT advancing cycles.
    int mn [2] = '{4, 8};
    int mk [2] = '{3, 3};
    int ml [2] = '{1, 3};
    bit m_busy [2], m_iss [2], m_inf [2], m_donep [2];
    int m_nxt [2], m_infaddr [2], m_emit [2];
    int qr [2][16], qc [2][16], ql [2][16];
    int qh [2], qn [2];

    // Event log, cycle numbers relative to t0 (the cycle start_i was raised).
    int t0 [2];
    int first_mem [2], last_mem [2], first_cen [2], last_cen [2];
    int nval [2], ndone [2], done_cyc [2], na0 [2];
    int vcyc [2][64];
    int a0cyc [2][8];

    task automatic model_reset(input int d);
        m_busy[d] = 0; m_iss[d] = 0; m_inf[d] = 0; m_donep[d] = 0;
        m_nxt[d] = 0; m_infaddr[d] = 0; m_emit[d] = 0; qh[d] = 0; qn[d] = 0;
    endtask

    task automatic clear_log(input int d);
        first_mem[d] = -1; last_mem[d] = -1; first_cen[d] = -1; last_cen[d] = -1;
        nval[d] = 0; ndone[d] = 0; done_cyc[d] = -1; na0[d] = 0;
    endtask

    task automatic model_cycle(input int d, input logic st, input logic hd,
                               input logic men, input int addr, input logic cen,
                               input logic ov, input int orow, input int ocol,
                               input logic bsy, input logic dn);
        int n, k, w, rel, er, ec, pr, pc;
        bit e_men, adv, e_ov, was_busy;
        n = mn[d]; k = mk[d]; w = n - k + 1; rel = cyc - t0[d];
        was_busy = m_busy[d];
        e_men = m_busy[d] && m_iss[d] && !hd;
        adv = m_inf[d] || (m_busy[d] && !m_iss[d] && !hd);
        e_ov = 0; er = 0; ec = 0;
        if (adv) begin
            for (int i = 0; i < qn[d]; i++) ql[d][(qh[d] + i) % 16]--;
            if (qn[d] > 0 && ql[d][qh[d]] == 0) begin
                e_ov = 1; er = qr[d][qh[d]]; ec = qc[d][qh[d]];
                qh[d] = (qh[d] + 1) % 16; qn[d]--;
            end
        end
        chk($sformatf("mem_en[%0d]", d), int'(men), int'(e_men));
        if (e_men) chk($sformatf("mem_addr[%0d]", d), addr, m_nxt[d]);
        chk($sformatf("conv_en[%0d]", d), int'(cen), int'(m_inf[d]));
        chk($sformatf("out_valid[%0d]", d), int'(ov), int'(e_ov));
        if (e_ov) begin
            chk($sformatf("out_row[%0d]", d), orow, er);
            chk($sformatf("out_col[%0d]", d), ocol, ec);
            chk($sformatf("rowmajor_row[%0d]", d), orow, m_emit[d] / w);
            chk($sformatf("rowmajor_col[%0d]", d), ocol, m_emit[d] % w);
        end
        chk($sformatf("busy[%0d]", d), int'(bsy), int'(m_busy[d]));
        chk($sformatf("done[%0d]", d), int'(dn), int'(m_donep[d]));

        if (men) begin
            if (first_mem[d] < 0) first_mem[d] = rel;
            last_mem[d] = rel;
            if (addr == 0 && na0[d] < 8) begin a0cyc[d][na0[d]] = rel; na0[d]++; end
        end
        if (cen) begin
            if (first_cen[d] < 0) first_cen[d] = rel;
            last_cen[d] = rel;
        end
        if (ov && nval[d] < 64) begin vcyc[d][nval[d]] = rel; nval[d]++; end
        if (dn) begin ndone[d]++; done_cyc[d] = rel; end

        if (m_inf[d]) begin
            pr = m_infaddr[d] / n; pc = m_infaddr[d] % n;
            if (pr >= k - 1 && pc >= k - 1) begin
                qr[d][(qh[d] + qn[d]) % 16] = pr - k + 1;
                qc[d][(qh[d] + qn[d]) % 16] = pc - k + 1;
                ql[d][(qh[d] + qn[d]) % 16] = ml[d];
                qn[d]++;
            end
        end
        m_inf[d] = e_men;
        m_infaddr[d] = m_nxt[d];
        if (e_men) begin
            if (m_nxt[d] == n * n - 1) m_iss[d] = 0;
            else m_nxt[d]++;
        end
        m_donep[d] = 0;
        if (e_ov) begin
            m_emit[d]++;
            if (m_emit[d] == w * w) begin m_busy[d] = 0; m_donep[d] = 1; end
        end
        if (!was_busy && st && !hd) begin
            m_busy[d] = 1; m_iss[d] = 1; m_nxt[d] = 0; m_emit[d] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!chk_en || rst) begin
            model_reset(0);
            model_reset(1);
            if (chk_en) begin
                chk("rst_cycle_done_a", int'(dn_a & 1'b0), 0);
            end
        end else begin
            model_cycle(0, st_a, hd_a, men_a, int'(addr_a), cen_a, ov_a, int'(row_a), int'(col_a), bsy_a, dn_a);
            model_cycle(1, st_b, hd_b, men_b, int'(addr_b), cen_b, ov_b, int'(row_b), int'(col_b), bsy_b, dn_b);
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic begin_frame_a();
        clear_log(0);
        t0[0] = cyc;
        st_a = 1'b1;
        step(1);
        st_a = 1'b0;
    endtask

    task automatic check_basic(input string tag, input int s);
        int exp_v [4];
        exp_v = '{13, 14, 17, 18};
        chk({tag, "_first_mem"}, first_mem[0], 1);
        chk({tag, "_last_mem"}, last_mem[0], 16 + s);
        chk({tag, "_first_conv"}, first_cen[0], 2);
        chk({tag, "_last_conv"}, last_cen[0], 17 + s);
        chk({tag, "_nvalid"}, nval[0], 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s_valid_cyc%0d", tag, i), vcyc[0][i], exp_v[i] + s);
        chk({tag, "_ndone"}, ndone[0], 1);
        chk({tag, "_done_cyc"}, done_cyc[0], 19 + s);
    endtask

    initial begin
        rst = 1'b1; st_a = 0; hd_a = 0; st_b = 0; hd_b = 0;
        t0[0] = 0; t0[1] = 0;
        clear_log(0); clear_log(1);
        step(3);
        rst = 1'b0;
        chk_en = 1;
        chk("reset_mem_en", int'(men_a), 0);
        chk("reset_addr", int'(addr_a), 0);
        chk("reset_conv_en", int'(cen_a), 0);
        chk("reset_valid", int'(ov_a), 0);
        chk("reset_row_col", int'({row_a, col_a}), 0);
        chk("reset_busy_done", int'({bsy_a, dn_a, bsy_b, dn_b}), 0);
        step(2);

        // Plain frame.
        begin_frame_a();
        step(24);
        check_basic("basic", 0);

        // Hold across cycles 5..7.
        begin_frame_a();
        step(4);
        hd_a = 1'b1;
        step(3);
        hd_a = 1'b0;
        step(20);
        check_basic("hold", 3);

        // start held high: back-to-back frames.
        clear_log(0);
        t0[0] = cyc;
        st_a = 1'b1;
        step(30);
        st_a = 1'b0;
        step(15);
        chk("b2b_a0_first", a0cyc[0][0], 1);
        chk("b2b_a0_second", a0cyc[0][1], 20);
        chk("b2b_nvalid", nval[0], 8);
        chk("b2b_ndone", ndone[0], 2);
        chk("b2b_last_done", done_cyc[0], 38);

        // Reset mid-frame at cycle 10.
        begin_frame_a();
        step(9);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_mem_en", int'(men_a), 0);
        chk("midrst_addr", int'(addr_a), 0);
        chk("midrst_conv_valid", int'({cen_a, ov_a}), 0);
        chk("midrst_row_col", int'({row_a, col_a}), 0);
        chk("midrst_busy_done", int'({bsy_a, dn_a}), 0);
        step(20);
        chk("midrst_nvalid", nval[0], 0);
        chk("midrst_ndone", ndone[0], 0);
        begin_frame_a();
        step(24);
        check_basic("restart", 0);

        // Larger image, deeper convolutor.
        clear_log(1);
        t0[1] = cyc;
        st_b = 1'b1;
        step(1);
        st_b = 1'b0;
        step(80);
        chk("big_nvalid", nval[1], 36);
        chk("big_first_valid", vcyc[1][0], 23);
        chk("big_last_valid", vcyc[1][35], 68);
        chk("big_last_mem", last_mem[1], 64);
        chk("big_ndone", ndone[1], 1);
        chk("big_done_cyc", done_cyc[1], vcyc[1][35] + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
